step_sequencer: RTL and testbench

- Parametrised successor to the 2-bit stage counter. Sequences the multi-cycle floating-point add datapath through the step indices 0..LAST.
- Adds a start/busy/done handshake, a synchronous abort, and first/last stage strobes.
- Sits between the adder control logic and the align/add/normalise/round stage muxes, which decode q.

---
 rtl/step_sequencer.sv | 122 ++++++++++++
 tb/tb_step_sequencer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/step_sequencer.sv
// Step sequencer for the multi-cycle FP add datapath: walks q through 0..LAST with a
// start/busy/done handshake and abort. Optional macro STEP_SEQUENCER_DOWN_EN adds count_down.
module step_sequencer #(
    parameter int WIDTH        = 2,
    parameter int LAST         = 3,
    parameter int AUTO_RESTART = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clk_en,
    input  logic             start,
    input  logic             abort,
`ifdef STEP_SEQUENCER_DOWN_EN
    input  logic             count_down,
`endif
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             stage_first,
    output logic             stage_last,
    output logic             done
);

    generate
        if (LAST < 1 || LAST > (2 ** WIDTH) - 1) begin : g_bad_last
            $error("step_sequencer: LAST must lie in 1..2^WIDTH-1");
        end
    endgenerate

    localparam logic [WIDTH-1:0] LAST_Q = WIDTH'(LAST);
    localparam logic [WIDTH-1:0] ZERO_Q = '0;
    localparam logic [WIDTH-1:0] ONE_Q  = WIDTH'(1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_q;
    logic             r_busy;
    logic             r_done;
    logic             r_down;

    logic             w_dir_in;
    logic [WIDTH-1:0] w_start_idx;
    logic [WIDTH-1:0] w_first_idx;
    logic [WIDTH-1:0] w_final_idx;
    logic [WIDTH-1:0] w_next_q;
    logic             w_on_final;

`ifdef STEP_SEQUENCER_DOWN_EN
    assign w_dir_in = count_down;
`else
    assign w_dir_in = 1'b0;
`endif

    // w_start_idx uses the direction being requested now; the others use the latched run direction.
    assign w_start_idx = w_dir_in ? LAST_Q : ZERO_Q;
    assign w_first_idx = r_down   ? LAST_Q : ZERO_Q;
    assign w_final_idx = r_down   ? ZERO_Q : LAST_Q;
    assign w_next_q    = r_down   ? (r_q - ONE_Q) : (r_q + ONE_Q);
    assign w_on_final  = (r_q == w_final_idx);

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples pre-edge values and the FSM order of statements cannot create races.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_q     <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_down  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (abort) begin
                r_state <= ST_IDLE;
                r_q     <= '0;
                r_busy  <= 1'b0;
            end else if (clk_en) begin
                case (r_state)
                    ST_IDLE: begin
                        if (start) begin
                            r_state <= ST_RUN;
                            r_q     <= w_start_idx;
                            r_busy  <= 1'b1;
                            r_down  <= w_dir_in;
                        end else begin
                            r_q <= '0;
                        end
                    end
                    ST_RUN: begin
                        if (!w_on_final) begin
                            r_q <= w_next_q;
                        end else begin
                            r_done <= 1'b1;
                            if ((AUTO_RESTART != 0) && start) begin
                                r_q    <= w_start_idx;
                                r_down <= w_dir_in;
                            end else begin
                                r_state <= ST_IDLE;
                                r_q     <= '0;
                                r_busy  <= 1'b0;
                            end
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_q     <= '0;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign q           = r_q;
    assign busy        = r_busy;
    assign done        = r_done;
    assign stage_first = r_busy && (r_q == w_first_idx);
    assign stage_last  = r_busy && (r_q == w_final_idx);

endmodule

// File: tb/tb_step_sequencer.sv
// Directed bench for step_sequencer: a default instance (WIDTH=2, LAST=3) and an
// AUTO_RESTART instance (WIDTH=3, LAST=5), checked cycle by cycle from an expectation queue.
module tb_step_sequencer;

    logic       clk      = 1'b0;
    logic       reset_n  = 1'b1;
    logic       clk_en   = 1'b0;
    logic       start    = 1'b0;
    logic       abort    = 1'b0;
    logic       start_ar = 1'b0;
`ifdef STEP_SEQUENCER_DOWN_EN
    logic       count_down = 1'b0;
`endif

    logic [1:0] q;
    logic       busy, sf, sl, done;
    logic [2:0] q_ar;
    logic       busy_ar, sf_ar, sl_ar, done_ar;

    always #5 clk = ~clk;

    step_sequencer #(.WIDTH(2), .LAST(3), .AUTO_RESTART(0)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .clk_en      (clk_en),
        .start       (start),
        .abort       (abort),
`ifdef STEP_SEQUENCER_DOWN_EN
        .count_down  (count_down),
`endif
        .q           (q),
        .busy        (busy),
        .stage_first (sf),
        .stage_last  (sl),
        .done        (done)
    );

    step_sequencer #(.WIDTH(3), .LAST(5), .AUTO_RESTART(1)) dut_ar (
        .clk         (clk),
        .reset_n     (reset_n),
        .clk_en      (clk_en),
        .start       (start_ar),
        .abort       (abort),
`ifdef STEP_SEQUENCER_DOWN_EN
        .count_down  (1'b0),
`endif
        .q           (q_ar),
        .busy        (busy_ar),
        .stage_first (sf_ar),
        .stage_last  (sl_ar),
        .done        (done_ar)
    );

    typedef struct packed {
        logic [2:0] q;
        logic       busy;
        logic       sf;
        logic       sl;
        logic       done;
    } exp_t;

    exp_t sb[$];
    exp_t sb_ar[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc_n = 0;

    task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed q/busy/first/last/done=%b expected=%b", tag, obs, expv);
        end
    endtask

    function automatic exp_t mk(input int qq, input bit b, input bit f, input bit l, input bit d);
        exp_t x;
        x.q    = qq[2:0];
        x.busy = b;
        x.sf   = f;
        x.sl   = l;
        x.done = d;
        return x;
    endfunction

    task automatic e(input int qq, input bit b, input bit f, input bit l, input bit d);
        sb.push_back(mk(qq, b, f, l, d));
    endtask

    task automatic ea(input int qq, input bit b, input bit f, input bit l, input bit d);
        sb_ar.push_back(mk(qq, b, f, l, d));
    endtask

    // One clock: sample #1 after the edge, compare against whatever was queued for it.
    task automatic tick();
        exp_t x;
        @(posedge clk);
        #1;
        cyc_n++;
        if (sb.size() > 0) begin
            x = sb.pop_front();
            check($sformatf("main@%0d", cyc_n), {1'b0, q, busy, sf, sl, done}, x);
        end
        if (sb_ar.size() > 0) begin
            x = sb_ar.pop_front();
            check($sformatf("ar@%0d", cyc_n), {q_ar, busy_ar, sf_ar, sl_ar, done_ar}, x);
        end
    endtask

    initial begin
        // Reset state
        #1 reset_n = 1'b0;
        #1;
        check("reset", {1'b0, q, busy, sf, sl, done}, 7'd0);
        check("reset_ar", {q_ar, busy_ar, sf_ar, sl_ar, done_ar}, 7'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Basic run with start held: no restart on final step, new run one cycle later
        clk_en = 1'b1;
        start  = 1'b1;
        e(0, 1, 1, 0, 0); tick();
        e(1, 1, 0, 0, 0); tick();
        e(2, 1, 0, 0, 0); tick();
        e(3, 1, 0, 1, 0); tick();
        e(0, 0, 0, 0, 1); tick();
        e(0, 1, 1, 0, 0); tick();
        start = 1'b0;
        e(1, 1, 0, 0, 0); tick();
        e(2, 1, 0, 0, 0); tick();

        // Abort together with start at q=2
        abort = 1'b1;
        start = 1'b1;
        e(0, 0, 0, 0, 0); tick();
        abort = 1'b0;
        start = 1'b0;
        e(0, 0, 0, 0, 0); tick();
        e(0, 0, 0, 0, 0); tick();

        // Abort on the final step suppresses done
        start = 1'b1;
        e(0, 1, 1, 0, 0); tick();
        start = 1'b0;
        e(1, 1, 0, 0, 0); tick();
        e(2, 1, 0, 0, 0); tick();
        e(3, 1, 0, 1, 0); tick();
        abort = 1'b1;
        e(0, 0, 0, 0, 0); tick();
        abort = 1'b0;
        e(0, 0, 0, 0, 0); tick();

        // Stall at q=1 with start ignored, then done stays single-cycle under clk_en=0
        start = 1'b1;
        e(0, 1, 1, 0, 0); tick();
        start = 1'b0;
        e(1, 1, 0, 0, 0); tick();
        clk_en = 1'b0;
        start  = 1'b1;
        e(1, 1, 0, 0, 0); tick();
        e(1, 1, 0, 0, 0); tick();
        e(1, 1, 0, 0, 0); tick();
        clk_en = 1'b1;
        start  = 1'b0;
        e(2, 1, 0, 0, 0); tick();
        e(3, 1, 0, 1, 0); tick();
        e(0, 0, 0, 0, 1); tick();
        clk_en = 1'b0;
        start  = 1'b1;
        e(0, 0, 0, 0, 0); tick();
        clk_en = 1'b1;
        start  = 1'b0;
        e(0, 0, 0, 0, 0); tick();

        // Reset dropped between edges at q=2
        start = 1'b1;
        e(0, 1, 1, 0, 0); tick();
        start = 1'b0;
        e(1, 1, 0, 0, 0); tick();
        e(2, 1, 0, 0, 0); tick();
        reset_n = 1'b0;
        #1;
        check("reset_mid", {1'b0, q, busy, sf, sl, done}, 7'd0);
        #1 reset_n = 1'b1;
        e(0, 0, 0, 0, 0); tick();
        e(0, 0, 0, 0, 0); tick();

        // AUTO_RESTART chain: two back-to-back passes, done at q=0 of the second
        start_ar = 1'b1;
        for (int i = 0; i <= 5; i++) begin
            ea(i, 1, i == 0, i == 5, 0); tick();
        end
        for (int i = 0; i <= 5; i++) begin
            ea(i, 1, i == 0, i == 5, i == 0); tick();
        end
        start_ar = 1'b0;
        ea(0, 0, 0, 0, 1); tick();
        ea(0, 0, 0, 0, 0); tick();

`ifdef STEP_SEQUENCER_DOWN_EN
        // Down run; count_down changes mid-run must not matter
        count_down = 1'b1;
        start      = 1'b1;
        e(3, 1, 1, 0, 0); tick();
        count_down = 1'b0;
        start      = 1'b0;
        e(2, 1, 0, 0, 0); tick();
        count_down = 1'b1;
        e(1, 1, 0, 0, 0); tick();
        count_down = 1'b0;
        e(0, 1, 0, 1, 0); tick();
        e(0, 0, 0, 0, 1); tick();
        e(0, 0, 0, 0, 0); tick();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
